// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the core front end.
//   - PcSrc encodings as produced by PC_Control.
//   - Default widths and reset PC for the fetch path.
//   - Fetch sequencer state encoding.
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT    = 32;
  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam logic [PC_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    PCSRC_HOLD   = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_SEQ    = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    FETCH  = 2'b01,
    DECODE = 2'b10,
    HALT   = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux: combinational next-PC select.
//   pc_src        : PcSrc code (hold / branch / jump / sequential)
//   pc            : current PC
//   pc_plus1      : current PC + 1 (wrapping)
//   branch_target : BEQ target
//   jump_target   : J/JAL target
//   next_pc       : selected next PC
module next_pc_mux
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [1:0]      pc_src,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    case (pc_src_e'(pc_src))
      PCSRC_SEQ:    next_pc = pc_plus1;
      PCSRC_BRANCH: next_pc = branch_target;
      PCSRC_JUMP:   next_pc = jump_target;
      default:      next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register and request/acknowledge instruction fetch.
//   clk, rst_n          : clock, async active-low reset
//   pc_src, next_valid  : PcSrc decision and its strobe (honoured in DECODE)
//   branch_target       : BEQ target
//   jump_target         : J/JAL target
//   imem_req/addr       : fetch request, address = pc
//   imem_ack/rdata      : memory response (honoured in FETCH)
//   instr, instr_valid  : registered instruction for decode
//   pc, pc_plus1        : current PC and its wrapping increment
//   halted              : sticky stop, cleared only by reset
//   fetch_count         : accepted next_valid strobes (wraps at 2^32)
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = PC_W_DEFAULT,
  parameter int unsigned      INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         pc_src,
  input  logic               next_valid,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    jump_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [31:0]        fetch_count_q, fetch_count_d;
  logic [PC_W-1:0]    next_pc;

  assign pc_plus1 = pc_q + PC_W'(1);

  next_pc_mux #(
    .PC_W (PC_W)
  ) u_next_pc_mux (
    .pc_src        (pc_src),
    .pc            (pc_q),
    .pc_plus1      (pc_plus1),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = DECODE;
        end
      end
      DECODE: begin
        if (next_valid) begin
          fetch_count_d = fetch_count_q + 32'd1;
          instr_valid_d = 1'b0;
          pc_d          = next_pc;
          if (pc_src_e'(pc_src) == PCSRC_HOLD) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            state_d  = FETCH;
          end
        end
      end
      HALT: begin
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Request decoded from the state register so reset drops it immediately.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        next_valid = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc, pc_plus1;
  logic        halted;
  logic [31:0] fetch_count;

  logic        w_rst_n = 1'b0;
  logic [1:0]  w_pc_src = 2'b00;
  logic        w_next_valid = 1'b0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic [31:0] w_instr;
  logic        w_instr_valid;
  logic [31:0] w_pc, w_pc_plus1;
  logic        w_halted;
  logic [31:0] w_fetch_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .next_valid(next_valid),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus1(pc_plus1), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .pc_src(w_pc_src), .next_valid(w_next_valid),
    .branch_target(32'h0), .jump_target(32'h0),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack),
    .imem_rdata(w_imem_rdata), .instr(w_instr), .instr_valid(w_instr_valid),
    .pc(w_pc), .pc_plus1(w_pc_plus1), .halted(w_halted), .fetch_count(w_fetch_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_proto  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: where the instruction stream is, at transaction level.
  //   booting      : one idle cycle after reset before the first request
  //   waiting      : a request for m_pc is outstanding
  //   holding      : an instruction is presented to decode
  //   stopped      : core parked
  typedef enum {M_BOOTING, M_WAITING, M_HOLDING, M_STOPPED} m_phase_t;
  m_phase_t    m_phase = M_BOOTING;
  logic [31:0] m_pc = '0, m_instr = '0, m_count = '0;
  logic        m_halted = 1'b0;
  logic        rst_next = 1'b0;

  task automatic compare_all();
    logic [31:0] inc;
    inc = m_pc + 32'd1;
    check_eq("imem_req",    {63'd0, imem_req},    {63'd0, m_phase == M_WAITING});
    check_eq("imem_addr",   {32'd0, imem_addr},   {32'd0, m_pc});
    check_eq("pc",          {32'd0, pc},          {32'd0, m_pc});
    check_eq("pc_plus1",    {32'd0, pc_plus1},    {32'd0, inc});
    check_eq("instr_valid", {63'd0, instr_valid}, {63'd0, m_phase == M_HOLDING});
    check_eq("instr",       {32'd0, instr},       {32'd0, m_instr});
    check_eq("halted",      {63'd0, halted},      {63'd0, m_halted});
    check_eq("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
  endtask

  task automatic model_update(input logic ack, input logic [31:0] rd, input logic nv,
                              input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt);
    if (!rst_n) begin
      m_phase = M_BOOTING; m_pc = '0; m_instr = '0; m_count = '0; m_halted = 1'b0;
      return;
    end
    if (nv && m_phase != M_HOLDING) n_proto++;
    case (m_phase)
      M_BOOTING: m_phase = M_WAITING;
      M_WAITING: if (ack) begin m_instr = rd; m_phase = M_HOLDING; end
      M_HOLDING: if (nv) begin
        m_count = m_count + 32'd1;
        if (src == 2'd0) begin m_halted = 1'b1; m_phase = M_STOPPED; end
        else begin
          if (src == 2'd3) m_pc = m_pc + 32'd1;
          else if (src == 2'd1) m_pc = bt;
          else m_pc = jt;
          m_phase = M_WAITING;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: check outputs, drive inputs, clock edge, advance model.
  task automatic step(input logic ack, input logic [31:0] rd, input logic nv,
                      input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt);
    @(negedge clk);
    compare_all();
    imem_ack = ack; imem_rdata = rd; next_valid = nv;
    pc_src = src; branch_target = bt; jump_target = jt;
    rst_n = rst_next;
    #1;
    if (!rst_n) check_eq("async_req", {63'd0, imem_req}, 64'd0);
    @(posedge clk);
    #1;
    model_update(ack, rd, nv, src, bt, jt);
  endtask

  task automatic idle();
    step(1'b0, $urandom, 1'b0, 2'($urandom), $urandom, $urandom);
  endtask

  // One instruction from FETCH: ack after ack_dly cycles (with stray
  // next_valid pulses), then next_valid after nv_dly cycles.
  task automatic insn(input int unsigned ack_dly, input int unsigned nv_dly,
                      input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt);
    for (int unsigned i = 0; i < ack_dly; i++)
      step(1'b0, $urandom, 1'($urandom), 2'($urandom), $urandom, $urandom);
    step(1'b1, $urandom, 1'b0, 2'($urandom), $urandom, $urandom);
    for (int unsigned i = 0; i < nv_dly; i++)
      step(1'($urandom), $urandom, 1'b0, 2'($urandom), $urandom, $urandom);
    step(1'($urandom), $urandom, 1'b1, src, bt, jt);
  endtask

  task automatic do_reset();
    rst_next = 1'b0;
    repeat (3) idle();
    rst_next = 1'b1;
    idle();  // BOOT cycle: request must still be low
  endtask

  initial begin
    // Wrap case on the all-ones reset PC instance.
    @(negedge clk);
    w_rst_n = 1'b1;
    check_eq("w_boot_req", {63'd0, w_imem_req}, 64'd0);
    @(negedge clk);
    check_eq("w_req", {63'd0, w_imem_req}, 64'd1);
    check_eq("w_addr", {32'd0, w_imem_addr}, 64'hFFFF_FFFF);
    check_eq("w_pc_plus1", {32'd0, w_pc_plus1}, 64'd0);
    w_imem_ack = 1'b1; w_imem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    w_imem_ack = 1'b0;
    check_eq("w_instr", {32'd0, w_instr}, 64'hCAFE_0001);
    w_next_valid = 1'b1; w_pc_src = 2'b11;
    @(negedge clk);
    w_next_valid = 1'b0;
    check_eq("w_wrap_addr", {32'd0, w_imem_addr}, 64'd0);
    check_eq("w_count", {32'd0, w_fetch_count}, 64'd1);

    // Reset and boot.
    do_reset();
    // Sequential stream, zero wait.
    for (int unsigned i = 0; i < 4; i++) insn(0, 0, 2'b11, $urandom, $urandom);
    check_eq("seq_count", {32'd0, fetch_count}, 64'd4);
    check_eq("seq_addr", {32'd0, imem_addr}, 64'd4);
    insn(0, 0, 2'b11, $urandom, $urandom);
    // Redirects.
    insn(0, 0, 2'b01, 32'h40, $urandom);
    check_eq("branch_addr", {32'd0, imem_addr}, 64'h40);
    insn(0, 1, 2'b10, $urandom, 32'h100);
    check_eq("jump_addr", {32'd0, imem_addr}, 64'h100);
    check_eq("jump_plus1", {32'd0, pc_plus1}, 64'h101);
    // Wait states with stray next_valid in FETCH.
    insn(3, 2, 2'b01, 32'd7, $urandom);
    // Stop.
    insn(0, 0, 2'b00, $urandom, $urandom);
    check_eq("stop_halted", {63'd0, halted}, 64'd1);
    check_eq("stop_pc", {32'd0, pc}, 64'd7);
    repeat (6) step(1'b1, $urandom, 1'b1, 2'($urandom), $urandom, $urandom);
    do_reset();
    check_eq("rst_pc", {32'd0, pc}, 64'd0);
    check_eq("rst_halted", {63'd0, halted}, 64'd0);
    // Async reset mid-FETCH, then stray acks.
    insn(0, 0, 2'b11, $urandom, $urandom);
    idle();
    rst_next = 1'b0;
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b11, '0, '0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 2'b11, '0, '0);
    rst_next = 1'b1;
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 2'b11, '0, '0);
    // Randomized traffic.
    for (int unsigned n = 0; n < 250; n++) begin
      logic [1:0] src;
      src = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      insn($urandom_range(0, 3), $urandom_range(0, 2), src, $urandom, $urandom);
      if (src == 2'b00) begin
        repeat (3) step(1'($urandom), $urandom, 1'($urandom), 2'($urandom), $urandom, $urandom);
        do_reset();
      end
    end
    idle();
    $display("note: %0d next_valid strobes outside DECODE (protocol errors, ignored by DUT)", n_proto);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
